// File: rtl/batpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : batpu_pkg
// Description : Shared types and constants for the BatPU2 writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
package batpu_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 4;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic                  cout;
        logic                  zero;
        logic [REG_ADDR_W-1:0] dest;
        logic                  write;
        logic                  set_flags;
    } wb_entry_t;

endpackage : batpu_pkg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Architectural register file, two async reads, one sync write,
//               r0 hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import batpu_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (waddr != ADDR_W'(REG_ZERO))) begin
            r_regs[waddr] <= wdata;
        end
    end

    // r0 reads are forced to zero rather than relying on the array contents.
    assign rdata_a = (raddr_a == ADDR_W'(REG_ZERO)) ? '0 : r_regs[raddr_a];
    assign rdata_b = (raddr_b == ADDR_W'(REG_ZERO)) ? '0 : r_regs[raddr_b];

endmodule : reg_file
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : One-entry writeback pipeline register with handshake, commit
//               to register file and Z/C flags, and operand/flag bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
    import batpu_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_W-1:0]     ex_result,
    input  logic                  ex_cout,
    input  logic                  ex_zero,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_write,
    input  logic                  ex_set_flags,
    input  logic                  wb_hold,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic                  flag_zero,
    output logic                  flag_carry
);

    logic              r_wb_valid;
    wb_entry_t         r_wb;
    logic              r_flag_z;
    logic              r_flag_c;

    logic              w_capture;
    logic              w_commit;
    wb_entry_t         w_ex_entry;
    logic [DATA_W-1:0] w_rf_a;
    logic [DATA_W-1:0] w_rf_b;

    assign ex_ready  = !r_wb_valid || !wb_hold;
    assign w_capture = ex_valid && ex_ready;
    assign w_commit  = r_wb_valid && !wb_hold;

    assign w_ex_entry = '{
        result:    ex_result,
        cout:      ex_cout,
        zero:      ex_zero,
        dest:      ex_dest,
        write:     ex_write,
        set_flags: ex_set_flags
    };

    // Commit and capture may coincide: old entry retires while the new one loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb       <= '0;
            r_flag_z   <= 1'b0;
            r_flag_c   <= 1'b0;
        end else begin
            if (w_commit && r_wb.set_flags) begin
                r_flag_z <= r_wb.zero;
                r_flag_c <= r_wb.cout;
            end
            if (w_capture) begin
                r_wb_valid <= 1'b1;
                r_wb       <= w_ex_entry;
            end else if (w_commit) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    reg_file #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (REG_ADDR_W)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we      (w_commit && r_wb.write),
        .waddr   (r_wb.dest),
        .wdata   (r_wb.result),
        .raddr_a (rd_addr_a),
        .raddr_b (rd_addr_b),
        .rdata_a (w_rf_a),
        .rdata_b (w_rf_b)
    );

    always_comb begin
        rd_data_a = w_rf_a;
        rd_data_b = w_rf_b;
        if (rd_addr_a == REG_ZERO) begin
            rd_data_a = '0;
        end else if (r_wb_valid && r_wb.write && (r_wb.dest == rd_addr_a)) begin
            rd_data_a = r_wb.result;
        end
        if (rd_addr_b == REG_ZERO) begin
            rd_data_b = '0;
        end else if (r_wb_valid && r_wb.write && (r_wb.dest == rd_addr_b)) begin
            rd_data_b = r_wb.result;
        end
    end

    assign flag_zero  = (r_wb_valid && r_wb.set_flags) ? r_wb.zero : r_flag_z;
    assign flag_carry = (r_wb_valid && r_wb.set_flags) ? r_wb.cout : r_flag_c;

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Scoreboard bench for writeback_stage against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic       clk;
    logic       rst;
    logic       ex_valid;
    logic       ex_ready;
    logic [7:0] ex_result;
    logic       ex_cout;
    logic       ex_zero;
    logic [3:0] ex_dest;
    logic       ex_write;
    logic       ex_set_flags;
    logic       wb_hold;
    logic [3:0] rd_addr_a;
    logic [3:0] rd_addr_b;
    logic [7:0] rd_data_a;
    logic [7:0] rd_data_b;
    logic       flag_zero;
    logic       flag_carry;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_stage #(
        .NUM_REGS (16),
        .DATA_W   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_result    (ex_result),
        .ex_cout      (ex_cout),
        .ex_zero      (ex_zero),
        .ex_dest      (ex_dest),
        .ex_write     (ex_write),
        .ex_set_flags (ex_set_flags),
        .wb_hold      (wb_hold),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of architectural and pending state
    logic [7:0] m_regs [16];
    logic       m_z, m_c;
    logic       m_pv, m_pw, m_ps, m_pz, m_pc;
    logic [7:0] m_pr;
    logic [3:0] m_pd;

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] b;
        logic       z;
        logic       c;
        logic       rdy;
    } exp_t;

    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [3:0] addr);
        if (addr == 4'd0) return 8'h00;
        if (m_pv && m_pw && m_pd == addr) return m_pr;
        return m_regs[addr];
    endfunction

    task automatic step(input string tag, input logic r, input logic v,
                        input logic [7:0] res, input logic co, input logic ze,
                        input logic [3:0] d, input logic w, input logic sf,
                        input logic h, input logic [3:0] aa, input logic [3:0] ab);
        logic cap, com;
        exp_t e;
        rst = r; ex_valid = v; ex_result = res; ex_cout = co; ex_zero = ze;
        ex_dest = d; ex_write = w; ex_set_flags = sf; wb_hold = h;
        rd_addr_a = aa; rd_addr_b = ab;

        if (r) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
            m_z = 0; m_c = 0; m_pv = 0;
            m_pr = 0; m_pd = 0; m_pw = 0; m_ps = 0; m_pz = 0; m_pc = 0;
        end else begin
            cap = v && (!m_pv || !h);
            com = m_pv && !h;
            if (com) begin
                if (m_pw && m_pd != 4'd0) m_regs[m_pd] = m_pr;
                if (m_ps) begin m_z = m_pz; m_c = m_pc; end
            end
            if (cap) begin
                m_pv = 1; m_pr = res; m_pc = co; m_pz = ze; m_pd = d; m_pw = w; m_ps = sf;
            end else if (com) begin
                m_pv = 0;
            end
        end

        e.tag = tag;
        e.a   = m_read(aa);
        e.b   = m_read(ab);
        e.z   = (m_pv && m_ps) ? m_pz : m_z;
        e.c   = (m_pv && m_ps) ? m_pc : m_c;
        e.rdy = !m_pv || !h;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq({e.tag, "/rd_a"},  32'(rd_data_a),  32'(e.a));
        check_eq({e.tag, "/rd_b"},  32'(rd_data_b),  32'(e.b));
        check_eq({e.tag, "/zero"},  32'(flag_zero),  32'(e.z));
        check_eq({e.tag, "/carry"}, 32'(flag_carry), 32'(e.c));
        check_eq({e.tag, "/ready"}, 32'(ex_ready),   32'(e.rdy));
    endtask

    task automatic idle(input string tag, input logic h, input logic [3:0] aa, input logic [3:0] ab);
        step(tag, 0, 0, 8'h00, 0, 0, 4'd0, 0, 0, h, aa, ab);
    endtask

    initial begin
        rst = 1; ex_valid = 0; ex_result = 0; ex_cout = 0; ex_zero = 0;
        ex_dest = 0; ex_write = 0; ex_set_flags = 0; wb_hold = 0;
        rd_addr_a = 0; rd_addr_b = 0;

        // Reset then read
        step("reset0", 1, 0, 8'h00, 0, 0, 4'd0, 0, 0, 0, 4'd5, 4'd0);
        step("reset1", 1, 0, 8'h00, 0, 0, 4'd0, 0, 0, 0, 4'd5, 4'd0);
        idle("post_reset", 0, 4'd5, 4'd0);
        check_eq("post_reset/abs_rd_a", 32'(rd_data_a), 32'h0);
        check_eq("post_reset/abs_ready", 32'(ex_ready), 32'h1);

        // Single write with flags
        step("single_cap", 0, 1, 8'h3C, 1, 0, 4'd3, 1, 1, 0, 4'd3, 4'd5);
        check_eq("single_cap/abs_rd_a", 32'(rd_data_a), 32'h3C);
        idle("single_commit", 0, 4'd3, 4'd3);
        check_eq("single_commit/abs_carry", 32'(flag_carry), 32'h1);

        // Back-to-back writes to r2
        step("b2b_1", 0, 1, 8'h11, 0, 0, 4'd2, 1, 0, 0, 4'd2, 4'd3);
        step("b2b_2", 0, 1, 8'h22, 0, 1, 4'd2, 1, 1, 0, 4'd2, 4'd3);
        check_eq("b2b_2/abs_rd_a", 32'(rd_data_a), 32'h22);
        idle("b2b_commit", 0, 4'd2, 4'd2);

        // r0 write discarded
        step("r0_write", 0, 1, 8'hFF, 1, 1, 4'd0, 1, 0, 0, 4'd2, 4'd0);
        idle("r0_commit", 0, 4'd3, 4'd0);

        // Hold: r4 <- 0x80 frozen while a second op is offered
        step("hold_cap", 0, 1, 8'h80, 0, 0, 4'd4, 1, 0, 0, 4'd4, 4'd5);
        for (int i = 0; i < 3; i++)
            step("hold", 0, 1, 8'h99, 0, 0, 4'd5, 1, 0, 1, 4'd4, 4'd5);
        check_eq("hold/abs_ready", 32'(ex_ready), 32'h0);
        step("hold_release", 0, 1, 8'h99, 0, 0, 4'd5, 1, 0, 0, 4'd4, 4'd5);
        idle("hold_drain", 0, 4'd4, 4'd5);

        // Reset mid-operation drops pending entry
        step("mid_cap", 0, 1, 8'h55, 1, 1, 4'd6, 1, 1, 0, 4'd6, 4'd4);
        step("mid_rst", 1, 0, 8'h00, 0, 0, 4'd0, 0, 0, 1, 4'd6, 4'd4);
        idle("mid_after", 1, 4'd6, 4'd4);

        // Hold with no pending entry has no effect
        idle("hold_empty", 1, 4'd1, 4'd2);

        // Randomised traffic
        for (int i = 0; i < 80; i++) begin
            step("rnd",
                 ($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)),
                 8'($urandom),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_writeback_stage
`default_nettype wire
